// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending-write (busy) bits, optional write-to-read
// forwarding and a multi-cycle clear sweep that walks registers 1..NREGS-1.
module scoreboard_regfile #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rd1_data,
  output logic [XLEN-1:0]          rd2_data,
  output logic                     rd1_busy,
  output logic                     rd2_busy,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     rsv_en,
  input  logic [$clog2(NREGS)-1:0] rsv_addr,
  input  logic                     clr_req,
  output logic                     clr_busy,
  output logic                     clr_done,
  output logic                     dbg_state
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     cnt;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  busy;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clr_req) state_next = SWEEP;
      SWEEP:   if (cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register 0 is never written, reserved or swept, so it stays zero and idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy     <= '0;
      state    <= IDLE;
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        clr_done <= 1'b0;
        if (we && wr_addr != '0) begin
          regs[wr_addr] <= wr_data;
          busy[wr_addr] <= 1'b0;
        end
        // Placed after the writeback so a same-address reservation wins.
        if (rsv_en && rsv_addr != '0) busy[rsv_addr] <= 1'b1;
        cnt <= clr_req ? AW'(1) : '0;
      end else begin
        regs[cnt] <= '0;
        busy[cnt] <= 1'b0;
        cnt       <= cnt + AW'(1);
        clr_done  <= (cnt == LAST);
      end
    end
  end

  // Forwarding only applies in IDLE, where the write actually takes effect.
  always_comb begin
    rd1_data = regs[rs1_addr];
    rd1_busy = busy[rs1_addr];
    if (BYPASS != 0 && state == IDLE && we && wr_addr == rs1_addr) begin
      rd1_data = wr_data;
      rd1_busy = rsv_en && (rsv_addr == rs1_addr);
    end
    if (rs1_addr == '0) begin
      rd1_data = '0;
      rd1_busy = 1'b0;
    end
  end

  always_comb begin
    rd2_data = regs[rs2_addr];
    rd2_busy = busy[rs2_addr];
    if (BYPASS != 0 && state == IDLE && we && wr_addr == rs2_addr) begin
      rd2_data = wr_data;
      rd2_busy = rsv_en && (rsv_addr == rs2_addr);
    end
    if (rs2_addr == '0) begin
      rd2_data = '0;
      rd2_busy = 1'b0;
    end
  end

  assign clr_busy  = (state == SWEEP);
  assign dbg_state = state;

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Bench for scoreboard_regfile: one forwarding instance (b_*) and one without
// forwarding (n_*) share every input; expected data flows through exp_q.
module tb_scoreboard_regfile;

  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;

  logic            clk;
  logic            reset;
  logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, rsv_addr;
  logic            we, rsv_en, clr_req;
  logic [XLEN-1:0] wr_data;

  logic [XLEN-1:0] b_rd1_data, b_rd2_data, n_rd1_data, n_rd2_data;
  logic            b_rd1_busy, b_rd2_busy, n_rd1_busy, n_rd2_busy;
  logic            b_clr_busy, b_clr_done, n_clr_busy, n_clr_done;
  logic            b_state, n_state;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] exp;
  int total;
  int bad;

  scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(b_rd1_data), .rd2_data(b_rd2_data), .rd1_busy(b_rd1_busy), .rd2_busy(b_rd2_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(b_clr_busy), .clr_done(b_clr_done), .dbg_state(b_state)
  );

  scoreboard_regfile #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd1_data(n_rd1_data), .rd2_data(n_rd2_data), .rd1_busy(n_rd1_busy), .rd2_busy(n_rd2_busy),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .clr_req(clr_req), .clr_busy(n_clr_busy), .clr_done(n_clr_done), .dbg_state(n_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic idle_inputs();
    we = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; clr_req = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    next_cycle();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int a = 0; a < NREGS; a++) begin
      rs1_addr = AW'(a); rs2_addr = AW'(NREGS - 1 - a);
      #1;
      if (b_rd1_data !== 32'h0 || n_rd1_data !== 32'h0) begin
        bad++; $display("FAIL reset_data a=%0d got=%h/%h exp=0", a, b_rd1_data, n_rd1_data);
      end
      total++;
      if (b_rd1_busy !== 1'b0 || b_rd2_busy !== 1'b0 || n_rd1_busy !== 1'b0) begin
        bad++; $display("FAIL reset_busy a=%0d got=%b%b%b exp=000", a, b_rd1_busy, b_rd2_busy, n_rd1_busy);
      end
      total++;
    end
    if (b_clr_busy !== 1'b0 || b_clr_done !== 1'b0 || b_state !== 1'b0) begin
      bad++; $display("FAIL reset_fsm got=%b%b%b exp=000", b_clr_busy, b_clr_done, b_state);
    end
    total++;
  endtask

  task automatic test_bypass();
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    if (b_rd1_data !== 32'hDEADBEEF || b_rd1_busy !== 1'b0) begin
      bad++; $display("FAIL bypass_fwd got=%h busy=%b exp=deadbeef busy=0", b_rd1_data, b_rd1_busy);
    end
    total++;
    if (n_rd1_data !== 32'h0) begin
      bad++; $display("FAIL nobypass_old got=%h exp=0", n_rd1_data);
    end
    total++;
    next_cycle();
    #1;
    exp = exp_q.pop_front();
    if (n_rd1_data !== exp || b_rd1_data !== exp) begin
      bad++; $display("FAIL write_visible got=%h/%h exp=%h", b_rd1_data, n_rd1_data, exp);
    end
    total++;
  endtask

  task automatic test_reserve();
    rs2_addr = 5'd7;
    rsv_en = 1'b1; rsv_addr = 5'd7;
    next_cycle();
    #1;
    if (b_rd2_busy !== 1'b1 || n_rd2_busy !== 1'b1) begin
      bad++; $display("FAIL rsv_busy got=%b/%b exp=1", b_rd2_busy, n_rd2_busy);
    end
    total++;
    // re-reserve an already busy register
    rsv_en = 1'b1; rsv_addr = 5'd7;
    next_cycle();
    #1;
    if (n_rd2_busy !== 1'b1) begin
      bad++; $display("FAIL rsv_again got=%b exp=1", n_rd2_busy);
    end
    total++;
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h12;
    exp_q.push_back(32'h12);
    #1;
    if (b_rd2_data !== 32'h12 || b_rd2_busy !== 1'b0 || n_rd2_busy !== 1'b1) begin
      bad++; $display("FAIL wb_same_cycle got=%h %b %b exp=12 0 1", b_rd2_data, b_rd2_busy, n_rd2_busy);
    end
    total++;
    next_cycle();
    #1;
    exp = exp_q.pop_front();
    if (n_rd2_data !== exp || n_rd2_busy !== 1'b0 || b_rd2_busy !== 1'b0) begin
      bad++; $display("FAIL wb_after got=%h %b %b exp=%h 0 0", n_rd2_data, n_rd2_busy, b_rd2_busy, exp);
    end
    total++;
    we = 1'b1; wr_addr = 5'd7; wr_data = 32'h34; rsv_en = 1'b1; rsv_addr = 5'd7;
    exp_q.push_back(32'h34);
    #1;
    if (b_rd2_data !== 32'h34 || b_rd2_busy !== 1'b1) begin
      bad++; $display("FAIL wb_rsv_fwd got=%h %b exp=34 1", b_rd2_data, b_rd2_busy);
    end
    total++;
    next_cycle();
    #1;
    exp = exp_q.pop_front();
    if (n_rd2_data !== exp || n_rd2_busy !== 1'b1 || b_rd2_busy !== 1'b1) begin
      bad++; $display("FAIL wb_rsv_after got=%h %b %b exp=%h 1 1", n_rd2_data, n_rd2_busy, b_rd2_busy, exp);
    end
    total++;
  endtask

  task automatic test_reg0();
    we = 1'b1; wr_addr = '0; wr_data = 32'hFFFFFFFF; rsv_en = 1'b1; rsv_addr = '0;
    rs1_addr = '0; rs2_addr = '0;
    #1;
    if (b_rd1_data !== 32'h0 || b_rd1_busy !== 1'b0) begin
      bad++; $display("FAIL reg0_same got=%h %b exp=0 0", b_rd1_data, b_rd1_busy);
    end
    total++;
    next_cycle();
    #1;
    if (b_rd2_data !== 32'h0 || n_rd2_data !== 32'h0 || b_rd2_busy !== 1'b0 || n_rd2_busy !== 1'b0) begin
      bad++; $display("FAIL reg0_after got=%h/%h exp=0", b_rd2_data, n_rd2_data);
    end
    total++;
  endtask

  task automatic fill_and_check();
    logic [XLEN-1:0] v;
    for (int a = 1; a < NREGS; a++) begin
      v = $urandom() | 32'h1;
      exp_q.push_back(v);
      do_write(AW'(a), v);
    end
    for (int a = 1; a < NREGS; a++) begin
      rs1_addr = AW'(a);
      #1;
      exp = exp_q.pop_front();
      if (n_rd1_data !== exp || b_rd1_data !== exp) begin
        bad++; $display("FAIL fill a=%0d got=%h exp=%h", a, n_rd1_data, exp);
      end
      total++;
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < NREGS; a++) begin
      rs1_addr = AW'(a); rs2_addr = AW'(a);
      #1;
      if (b_rd1_data !== 32'h0 || n_rd2_data !== 32'h0 || b_rd1_busy !== 1'b0 || n_rd2_busy !== 1'b0) begin
        bad++; $display("FAIL %s a=%0d got=%h/%h busy=%b%b exp=0", tag, a, b_rd1_data, n_rd2_data, b_rd1_busy, n_rd2_busy);
      end
      total++;
    end
  endtask

  task automatic test_sweep();
    int busy_cycles;
    int done_count;
    int done_at;
    fill_and_check();
    rsv_en = 1'b1; rsv_addr = 5'd9;
    next_cycle();
    clr_req = 1'b1;
    next_cycle();
    busy_cycles = 0; done_count = 0; done_at = -1;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) begin
        we = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; rsv_en = 1'b1; rsv_addr = 5'd4;
      end
      if (i == 8) clr_req = 1'b1;
      #1;
      if (b_clr_busy) busy_cycles++;
      if (b_clr_done) begin done_count++; done_at = i; end
      next_cycle();
    end
    if (busy_cycles !== 31) begin
      bad++; $display("FAIL sweep_len got=%0d exp=31", busy_cycles);
    end
    total++;
    if (done_count !== 1 || done_at !== 31) begin
      bad++; $display("FAIL sweep_done got=%0d at %0d exp=1 at 31", done_count, done_at);
    end
    total++;
    check_all_zero("sweep_zero");
  endtask

  task automatic test_back_to_back();
    int busy_cycles;
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_0009;
    rsv_en = 1'b1; rsv_addr = 5'd10; clr_req = 1'b1;
    exp_q.push_back(32'hA5A5_0009);
    next_cycle();
    rs1_addr = 5'd9; rs2_addr = 5'd10;
    #1;
    exp = exp_q.pop_front();
    if (n_rd1_data !== exp || n_rd2_busy !== 1'b1 || n_clr_busy !== 1'b1) begin
      bad++; $display("FAIL b2b_before got=%h %b %b exp=%h 1 1", n_rd1_data, n_rd2_busy, n_clr_busy, exp);
    end
    total++;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (n_clr_busy) busy_cycles++;
      next_cycle();
    end
    if (busy_cycles !== 31) begin
      bad++; $display("FAIL b2b_len got=%0d exp=31", busy_cycles);
    end
    total++;
    check_all_zero("b2b_zero");
  endtask

  task automatic test_reset_mid_sweep();
    int done_count;
    for (int a = 1; a < NREGS; a++) do_write(AW'(a), 32'(a + 100));
    clr_req = 1'b1;
    next_cycle();
    repeat (9) next_cycle();
    rs1_addr = 5'd31; rs2_addr = 5'd20;
    #1;
    if (b_rd1_data !== 32'd131 || b_clr_busy !== 1'b1) begin
      bad++; $display("FAIL mid_sweep got=%h %b exp=%h 1", b_rd1_data, b_clr_busy, 32'd131);
    end
    total++;
    #1 reset = 1'b0;
    #1;
    if (b_rd1_data !== 32'h0 || n_rd2_data !== 32'h0 || b_clr_busy !== 1'b0 || n_state !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%h/%h %b %b exp=0 0 0", b_rd1_data, n_rd2_data, b_clr_busy, n_state);
    end
    total++;
    @(negedge clk);
    reset = 1'b1;
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (b_clr_done || n_clr_done || b_clr_busy) done_count++;
      next_cycle();
    end
    if (done_count !== 0) begin
      bad++; $display("FAIL no_resume got=%0d exp=0", done_count);
    end
    total++;
    check_all_zero("reset_zero");
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_bypass();
    test_reserve();
    test_reg0();
    test_sweep();
    test_back_to_back();
    test_reset_mid_sweep();
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL queue_left got=%0d exp=0", exp_q.size());
    end
    total++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
